// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and map address helper
// for the tile map scheduler.
package vga_pkg;

    localparam int HLEFT_D   = 144;
    localparam int VTOP_D    = 31;
    localparam int COLS_D    = 40;
    localparam int ROWS_D    = 30;
    localparam int MAP_DEPTH = 1200;
    localparam int AW        = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fill_state_e;

    // row*40 + col without a multiplier
    function automatic logic [AW-1:0] map_addr(
        input logic [4:0] row,
        input logic [5:0] col
    );
        logic [AW-1:0] r;
        r = {6'd0, row};
        return (r << 5) + (r << 3) + {5'd0, col};
    endfunction

endpackage

// File: rtl/tile_map_scheduler_if.sv
// Host write channel and fill control for the tile map scheduler.
// master = host side, slave = scheduler side.
interface tile_map_scheduler_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_col;
    logic [4:0] wr_row;
    logic [3:0] wr_tile;
    logic       wr_err;
    logic       clear_req;
    logic [3:0] clear_val;
    logic       clear_busy;
    logic       clear_done;

    modport master (
        output wr_valid, wr_col, wr_row, wr_tile,
        output clear_req, clear_val,
        input  wr_ready, wr_err, clear_busy, clear_done
    );

    modport slave (
        input  wr_valid, wr_col, wr_row, wr_tile,
        input  clear_req, clear_val,
        output wr_ready, wr_err, clear_busy, clear_done
    );

endinterface

// File: rtl/tile_map_ram.sv
// Single-port 1200x4 tile map, synchronous write, registered read.
// Kept standalone so it maps onto a block RAM.
module tile_map_ram
    import vga_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    wdata,
    output logic [3:0]    rdata
);

    logic [3:0] mem_q [MAP_DEPTH];
    logic [3:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tile_map_scheduler.sv
// Tile map owner: prefetches one tile index per 16-pixel tile and
// arbitrates the map RAM between display, fill engine and host writes.
module tile_map_scheduler
    import vga_pkg::*;
#(
    parameter int HLEFT = HLEFT_D,
    parameter int VTOP  = VTOP_D,
    parameter int COLS  = COLS_D,
    parameter int ROWS  = ROWS_D
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic [3:0] tselect,
    tile_map_scheduler_if.slave bus
);

    logic [9:0]    px;
    logic [9:0]    py;
    logic [10:0]   nx;
    logic [6:0]    nx_col;
    logic          slot;
    logic [AW-1:0] disp_addr;
    logic          wr_in_range;
    logic          wr_ready;
    logic          wr_fire;
    logic          fill_fire;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_wdata;
    logic [3:0]    ram_rdata;

    fill_state_e   state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    val_q, val_d;
    logic [3:0]    tsel_q, tsel_d;
    logic          rd_pend_q, rd_pend_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    // Fetch two pixels ahead; the 10-bit wrap makes the first
    // tile of a line land on column 0 at hcount = HLEFT-1.
    always_comb begin
        px        = hcount - 10'(HLEFT) - 10'd1;
        py        = vcount - 10'(VTOP) - 10'd1;
        nx        = {1'b0, px + 10'd2};
        nx_col    = nx[10:4];
        slot      = (nx[3:0] == 4'd0) && (nx_col < 7'(COLS))
                    && (py < 10'(ROWS * 16));
        disp_addr = map_addr(py[8:4], nx_col[5:0]);
    end

    always_comb begin
        wr_in_range = (bus.wr_col < 6'(COLS)) && (bus.wr_row < 5'(ROWS));
        wr_ready    = !rst && (state_q == IDLE) && !slot && !bus.clear_req;
        wr_fire     = bus.wr_valid && wr_ready;
        fill_fire   = !rst && (state_q == CLEAR) && !slot;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_wdata = val_q;
        unique case (1'b1)
            slot: begin
                ram_we = 1'b0;
            end
            fill_fire: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = val_q;
            end
            wr_fire: begin
                ram_we    = wr_in_range;
                ram_addr  = map_addr(bus.wr_row, bus.wr_col);
                ram_wdata = bus.wr_tile;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    tile_map_ram u_ram (
        .clk   (clk1),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        val_d     = val_q;
        done_d    = 1'b0;
        err_d     = wr_fire && !wr_in_range;
        rd_pend_d = slot;
        tsel_d    = rd_pend_q ? ram_rdata : tsel_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    val_d   = bus.clear_val;
                end
            end
            CLEAR: begin
                if (fill_fire) begin
                    if (addr_q == AW'(MAP_DEPTH - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset starts a zero fill so the map never shows stale contents.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= CLEAR;
            addr_q    <= '0;
            val_q     <= '0;
            tsel_q    <= '0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            val_q     <= val_d;
            tsel_q    <= tsel_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign tselect        = tsel_q;
    assign bus.wr_ready   = wr_ready;
    assign bus.wr_err     = err_q;
    assign bus.clear_busy = (state_q == CLEAR);
    assign bus.clear_done = done_q;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Directed bench for tile_map_scheduler: fill, display fetch,
// host writes, range errors, clear arbitration and reset mid-fill.
module tb_tile_map_scheduler;

    logic       clk1 = 1'b0;
    logic       rst;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [3:0] tselect;

    int checks = 0;
    int errors = 0;
    logic [3:0] map_m [1200];

    tile_map_scheduler_if bus ();

    tile_map_scheduler dut (
        .clk1    (clk1),
        .rst     (rst),
        .hcount  (hcount),
        .vcount  (vcount),
        .tselect (tselect),
        .bus     (bus)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic bit is_slot(input int h, input int v);
        int px, py, nx;
        px = (h - 145) & 1023;
        py = (v - 32) & 1023;
        nx = (px + 2) & 1023;
        return (nx % 16 == 0) && (nx / 16 < 40) && (py < 480);
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic run_line(input int v, input bit chk);
        int row;
        row = (v - 32) / 16;
        for (int h = 140; h < 790; h++) begin
            hcount = 10'(h);
            vcount = 10'(v);
            @(negedge clk1);
            if (chk && h >= 145 && h <= 784)
                check($sformatf("tsel v%0d h%0d", v, h), tselect,
                      map_m[row * 40 + (h - 145) / 16]);
            tick();
        end
    endtask

    task automatic host_write(input int col, input int row,
                              input int tile, output bit acc);
        acc = 1'b0;
        hcount = 10'd0;
        vcount = 10'd0;
        bus.wr_valid = 1'b1;
        bus.wr_col = 6'(col);
        bus.wr_row = 5'(row);
        bus.wr_tile = 4'(tile);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk1);
            if (bus.wr_ready) begin
                tick();
                acc = 1'b1;
                break;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        if (acc && col < 40 && row < 30)
            map_m[row * 40 + col] = 4'(tile);
    endtask

    task automatic show_all(input int phase);
        for (int r = 0; r < 30; r++)
            run_line(32 + 16 * r + ((r + phase) & 15), 1'b1);
    endtask

    initial begin
        bit acc;
        int busy_n, done_n, stall_n, drops, idx, w, early;

        foreach (map_m[i]) map_m[i] = 4'd0;
        rst = 1'b1;
        hcount = 10'd0;
        vcount = 10'd0;
        bus.wr_valid = 1'b1;
        bus.wr_col = 6'd0;
        bus.wr_row = 5'd0;
        bus.wr_tile = 4'd15;
        bus.clear_req = 1'b0;
        bus.clear_val = 4'd0;

        tick();
        tick();
        @(negedge clk1);
        check("rst_tsel", tselect, 0);
        check("rst_err", bus.wr_err, 0);
        check("rst_done", bus.clear_done, 0);
        check("rst_busy", bus.clear_busy, 1);
        check("rst_ready", bus.wr_ready, 0);
        tick();
        rst = 1'b0;
        bus.wr_valid = 1'b0;

        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk1);
            if (bus.clear_done) begin
                done_n++;
                check("fill_busy_at_done", bus.clear_busy, 0);
                break;
            end
            if (bus.clear_busy) busy_n++;
            tick();
        end
        tick();
        check("fill_cycles", busy_n, 1200);
        check("fill_done_seen", done_n, 1);
        early = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            if (bus.clear_done) early++;
            tick();
        end
        check("fill_done_once", early, 0);
        show_all(0);

        host_write(0, 0, 5, acc);
        check("wr00_acc", acc, 1);
        host_write(39, 29, 9, acc);
        check("wr3929_acc", acc, 1);
        host_write(0, 3, 2, acc);
        check("wr03_acc", acc, 1);
        run_line(32, 1'b1);
        run_line(47, 1'b1);
        run_line(496, 1'b1);
        run_line(511, 1'b1);

        host_write(40, 3, 10, acc);
        check("err_acc", acc, 1);
        @(negedge clk1);
        check("wr_err_pulse", bus.wr_err, 1);
        tick();
        @(negedge clk1);
        check("wr_err_clear", bus.wr_err, 0);
        tick();
        run_line(85, 1'b1);
        run_line(100, 1'b1);

        idx = 0;
        drops = 0;
        bus.wr_valid = 1'b1;
        for (int h = 140; h < 790; h++) begin
            hcount = 10'(h);
            vcount = 10'd48;
            bus.wr_col = 6'((400 + idx) % 40);
            bus.wr_row = 5'((400 + idx) / 40);
            bus.wr_tile = 4'((idx * 3 + 1) & 15);
            @(negedge clk1);
            check($sformatf("stream_ready h%0d", h), bus.wr_ready,
                  !is_slot(h, 48));
            if (bus.wr_ready) begin
                map_m[400 + idx] = bus.wr_tile;
                idx++;
            end else begin
                drops++;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
        check("stream_drops", drops, 40);
        for (int r = 10; r < 30; r++)
            run_line(32 + 16 * r + 5, 1'b1);

        busy_n = 0;
        stall_n = 0;
        done_n = 0;
        for (int n = 0; n < 6000; n++) begin
            hcount = 10'(140 + n % 650);
            vcount = 10'(32 + n / 650);
            bus.clear_req = (n == 10);
            bus.clear_val = 4'd7;
            bus.wr_valid = (n == 10);
            bus.wr_col = 6'd5;
            bus.wr_row = 5'd5;
            bus.wr_tile = 4'd3;
            @(negedge clk1);
            if (n == 10) check("clr_blocks_wr", bus.wr_ready, 0);
            if (n > 10) begin
                if (bus.clear_done) begin
                    done_n++;
                    break;
                end
                if (bus.clear_busy) begin
                    busy_n++;
                    if (is_slot(140 + n % 650, 32 + n / 650)) stall_n++;
                    check("clr_ready_low", bus.wr_ready, 0);
                end
            end
            tick();
        end
        tick();
        bus.clear_req = 1'b0;
        bus.wr_valid = 1'b0;
        check("clr_done_seen", done_n, 1);
        check("clr_fill_writes", busy_n - stall_n, 1200);
        foreach (map_m[i]) map_m[i] = 4'd7;
        show_all(9);

        hcount = 10'd0;
        vcount = 10'd0;
        bus.clear_req = 1'b1;
        bus.clear_val = 4'd3;
        tick();
        bus.clear_req = 1'b0;
        w = 0;
        early = 0;
        for (int i = 0; i < 2000; i++) begin
            bus.clear_req = (w == 100);
            bus.clear_val = 4'd5;
            @(negedge clk1);
            if (bus.clear_done) early++;
            if (bus.clear_busy) w++;
            tick();
            if (w == 600) break;
        end
        check("midfill_writes", w, 600);
        check("midfill_no_done", early, 0);
        bus.clear_req = 1'b0;
        rst = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_col = 6'd0;
        bus.wr_row = 5'd0;
        bus.wr_tile = 4'd15;
        @(negedge clk1);
        check("rst_blocks_wr", bus.wr_ready, 0);
        tick();
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        w = 0;
        done_n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk1);
            if (bus.clear_done) begin
                done_n++;
                break;
            end
            if (bus.clear_busy) w++;
            tick();
        end
        tick();
        check("refill_done_seen", done_n, 1);
        check("refill_writes", w, 1200);
        foreach (map_m[i]) map_m[i] = 4'd0;
        run_line(32, 1'b1);
        run_line(300, 1'b1);
        run_line(511, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
